// File: rtl/cla_pipe_adder.sv
// -----------------------------------------------------------------------------
// cla_pipe_adder
//
// Pipelined carry-lookahead adder. The operands are cut into GROUP-bit groups.
// Pipeline stage k (k = 1..NG) resolves group k-1 with a flat two-level
// lookahead, using that group's generate/propagate terms and the group carry
// registered by the previous stage. The critical path is one group deep,
// whatever the total width. A single global advance enable stalls every stage
// at once whenever the output is valid but not being taken.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset (clears valids and result regs)
//   in_valid   a, b, Ci carry an operation
//   in_ready   pipeline accepts this cycle (= advance enable, combinational)
//   a, b       WIDTH-bit operands (unsigned or two's complement)
//   Ci         carry in
//   out_valid  sum, Co, ovf hold a result
//   out_ready  consumer takes the result this cycle
//   sum        low WIDTH bits of a + b + Ci
//   Co         carry out of bit WIDTH-1
//   ovf        signed overflow (carry into MSB xor carry out of MSB)
// -----------------------------------------------------------------------------
module cla_pipe_adder #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             Ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             Co,
    output logic             ovf
);

    localparam int NG = WIDTH / GROUP;

    if (GROUP < 2 || GROUP > 8 || WIDTH < GROUP || (WIDTH % GROUP) != 0) begin : g_param_check
        $error("cla_pipe_adder: WIDTH must be a non-zero multiple of GROUP, GROUP in 2..8");
    end

    // Global stall: every stage moves together or not at all.
    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    for (genvar s = 0; s < NG; s++) begin : g_stage
        // Bits [HI-1:0] of the sum are final once this stage has loaded.
        localparam int HI = (s + 1) * GROUP;

        logic             vld_in;
        logic             cin;
        logic [GROUP-1:0] ga;
        logic [GROUP-1:0] gb;
        logic [GROUP-1:0] p;
        logic [GROUP-1:0] g;
        logic [GROUP:0]   c;
        logic             vld_d, vld_q;
        logic             cout_d, cout_q;
        logic [HI-1:0]    sum_d, sum_q;

        // Stage 1 reads the ports; later stages read the previous stage's
        // registered carry and the low group of its leftover operand bits.
        if (s == 0) begin : g_src
            assign vld_in = in_valid;
            assign cin    = Ci;
            assign ga     = a[GROUP-1:0];
            assign gb     = b[GROUP-1:0];
        end else begin : g_src
            assign vld_in = g_stage[s-1].vld_q;
            assign cin    = g_stage[s-1].cout_q;
            assign ga     = g_stage[s-1].g_ops.a_q[GROUP-1:0];
            assign gb     = g_stage[s-1].g_ops.b_q[GROUP-1:0];
        end

        assign p = ga ^ gb;
        assign g = ga & gb;

        // Every carry is an explicit sum of products:
        //   c[i+1] = g[i] | p[i]g[i-1] | ... | p[i]..p[0]cin
        // The loops only enumerate product terms; no term depends on an
        // earlier carry, so there is no ripple path inside the group.
        always_comb begin
            logic term;
            // NOTE: every variable gets a value before any branch or loop so
            // no path leaves it unassigned, which would infer a latch.
            term = 1'b0;
            c    = '0;
            c[0] = cin;
            for (int i = 0; i < GROUP; i++) begin
                term = cin;
                for (int k = 0; k <= i; k++) begin
                    term = term & p[k];
                end
                c[i+1] = term;
                for (int j = 0; j <= i; j++) begin
                    term = g[j];
                    for (int k = j + 1; k <= i; k++) begin
                        term = term & p[k];
                    end
                    c[i+1] = c[i+1] | term;
                end
            end
        end

        if (s == 0) begin : g_sum
            always_comb sum_d = p ^ c[GROUP-1:0];
        end else begin : g_sum
            always_comb sum_d = {p ^ c[GROUP-1:0], g_stage[s-1].sum_q};
        end

        always_comb begin
            vld_d  = vld_in;
            cout_d = c[GROUP];
        end

        // NOTE: state is updated with non-blocking assignments so every flop
        // samples the pre-edge values of its neighbours, independent of
        // block evaluation order.
        always_ff @(posedge clk) begin
            if (reset) begin
                vld_q  <= 1'b0;
                cout_q <= 1'b0;
                sum_q  <= '0;
            end else if (adv) begin
                vld_q  <= vld_d;
                cout_q <= cout_d;
                sum_q  <= sum_d;
            end
        end

        // Operand bits not yet consumed travel alongside the partial sum.
        if (s < NG - 1) begin : g_ops
            logic [WIDTH-HI-1:0] a_d, a_q;
            logic [WIDTH-HI-1:0] b_d, b_q;

            if (s == 0) begin : g_in
                always_comb begin
                    a_d = a[WIDTH-1:HI];
                    b_d = b[WIDTH-1:HI];
                end
            end else begin : g_in
                always_comb begin
                    a_d = g_stage[s-1].g_ops.a_q[WIDTH-HI+GROUP-1:GROUP];
                    b_d = g_stage[s-1].g_ops.b_q[WIDTH-HI+GROUP-1:GROUP];
                end
            end

            // NOTE: pure datapath with no reset; a stale value here only ever
            // travels next to a cleared valid bit and is never reported.
            always_ff @(posedge clk) begin
                if (adv) begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end
        end

        // The last group sees the MSB, so it alone can form signed overflow.
        if (s == NG - 1) begin : g_last
            logic ovf_d, ovf_q;

            always_comb ovf_d = c[GROUP-1] ^ c[GROUP];

            always_ff @(posedge clk) begin
                if (reset) begin
                    ovf_q <= 1'b0;
                end else if (adv) begin
                    ovf_q <= ovf_d;
                end
            end
        end
    end

    assign out_valid = g_stage[NG-1].vld_q;
    assign sum       = g_stage[NG-1].sum_q;
    assign Co        = g_stage[NG-1].cout_q;
    assign ovf       = g_stage[NG-1].g_last.ovf_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// -----------------------------------------------------------------------------
// tb_cla_pipe_adder
//
// Main instance (WIDTH=16, GROUP=4): directed vector table, latency, stall,
// mid-flight reset and random traffic with random back-pressure, all checked
// against a transaction-level model (FIFO of results with edge ages).
// Two extra instances (8/2 and 32/8) run 1000 random operations each with
// out_ready held high; every result must appear exactly NG cycles later.
// -----------------------------------------------------------------------------
module tb_cla_pipe_adder;

    localparam int W  = 16;
    localparam int G  = 4;
    localparam int NG = W / G;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         Ci;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         Co;
    logic         ovf;

    int n_checks = 0;
    int n_errors = 0;
    int n_retired = 0;

    cla_pipe_adder #(.WIDTH(W), .GROUP(G)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .Ci        (Ci),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .Co        (Co),
        .ovf       (ovf)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ci;
        logic [W-1:0] s;
        logic         co;
        logic         ovf;
    } vec_t;

    // One in-flight result; age = number of advancing edges since acceptance.
    typedef struct {
        logic [W-1:0] s;
        logic         co;
        logic         ovf;
        int           age;
    } ent_t;

    ent_t mq[$];

    function automatic ent_t ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        logic [W:0] full;
        ent_t       e;
        full  = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
        e.s   = full[W-1:0];
        e.co  = full[W];
        e.ovf = (x[W-1] == y[W-1]) && (e.s[W-1] != x[W-1]);
        e.age = 0;
        return e;
    endfunction

    // Called at a negedge: drive inputs, check in_ready, take the edge,
    // update the model, then check the outputs at the following negedge.
    task automatic cycle(input logic iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic ici, input logic ordy, input ent_t e, output logic acc);
        logic head_done;
        logic m_adv;
        in_valid  = iv;
        a         = ia;
        b         = ib;
        Ci        = ici;
        out_ready = ordy;
        head_done = (mq.size() > 0) && (mq[0].age == NG);
        m_adv     = !head_done || ordy;
        #1;
        check("in_ready", 64'(in_ready), 64'(m_adv));
        @(posedge clk);
        if (m_adv) begin
            if (head_done) begin
                void'(mq.pop_front());
                n_retired++;
            end
            for (int i = 0; i < mq.size(); i++) mq[i].age++;
            if (iv) begin
                e.age = 1;
                mq.push_back(e);
            end
        end
        acc = iv && m_adv;
        @(negedge clk);
        head_done = (mq.size() > 0) && (mq[0].age == NG);
        check("out_valid", 64'(out_valid), 64'(head_done));
        if (head_done) begin
            check("sum", 64'(sum), 64'(mq[0].s));
            check("Co",  64'(Co),  64'(mq[0].co));
            check("ovf", 64'(ovf), 64'(mq[0].ovf));
        end
    endtask

    task automatic idle(input int n);
        ent_t e;
        logic acc;
        e = ref_add('0, '0, 1'b0);
        repeat (n) cycle(1'b0, '0, '0, 1'b0, 1'b1, e, acc);
    endtask

    task automatic pulse_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        mq.delete();
        @(negedge clk);
        reset = 1'b0;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_sum",       64'(sum),       64'(0));
        check("rst_Co",        64'(Co),        64'(0));
        check("rst_ovf",       64'(ovf),       64'(0));
    endtask

    // ---------------------------------------------------------------- sweeps
    for (genvar k = 0; k < 2; k++) begin : g_sweep
        localparam int SW = (k == 0) ? 8 : 32;
        localparam int SG = (k == 0) ? 2 : 8;
        localparam int SN = SW / SG;

        typedef struct {
            logic [SW-1:0] s;
            logic          co;
            logic          ovf;
            int            due;
        } sent_t;

        logic          s_rst;
        logic          s_iv;
        logic          s_irdy;
        logic          s_ci;
        logic          s_ov;
        logic          s_co;
        logic          s_ovf;
        logic [SW-1:0] s_a;
        logic [SW-1:0] s_b;
        logic [SW-1:0] s_sum;
        logic          done = 1'b0;
        sent_t         q[$];

        cla_pipe_adder #(.WIDTH(SW), .GROUP(SG)) dut (
            .clk       (clk),
            .reset     (s_rst),
            .in_valid  (s_iv),
            .in_ready  (s_irdy),
            .a         (s_a),
            .b         (s_b),
            .Ci        (s_ci),
            .out_valid (s_ov),
            .out_ready (1'b1),
            .sum       (s_sum),
            .Co        (s_co),
            .ovf       (s_ovf)
        );

        initial begin
            int            sent;
            int            cyc;
            logic [SW:0]   full;
            sent_t         e;
            sent  = 0;
            cyc   = 0;
            s_rst = 1'b1;
            s_iv  = 1'b0;
            s_a   = '0;
            s_b   = '0;
            s_ci  = 1'b0;
            repeat (2) @(negedge clk);
            s_rst = 1'b0;
            while ((sent < 1000 || q.size() > 0) && cyc < 5000) begin
                if (q.size() > 0 && q[0].due == cyc) begin
                    check($sformatf("w%0d_out_valid", SW), 64'(s_ov),    64'(1));
                    check($sformatf("w%0d_sum", SW),       64'(s_sum),   64'(q[0].s));
                    check($sformatf("w%0d_Co", SW),        64'(s_co),    64'(q[0].co));
                    check($sformatf("w%0d_ovf", SW),       64'(s_ovf),   64'(q[0].ovf));
                    void'(q.pop_front());
                end else begin
                    check($sformatf("w%0d_out_valid", SW), 64'(s_ov), 64'(0));
                end
                check($sformatf("w%0d_in_ready", SW), 64'(s_irdy), 64'(1));
                s_iv = (sent < 1000) && ($urandom_range(0, 3) != 0);
                s_a  = SW'($urandom());
                s_b  = SW'($urandom());
                s_ci = 1'($urandom_range(0, 1));
                if (s_iv) begin
                    full  = {1'b0, s_a} + {1'b0, s_b} + {{SW{1'b0}}, s_ci};
                    e.s   = full[SW-1:0];
                    e.co  = full[SW];
                    e.ovf = (s_a[SW-1] == s_b[SW-1]) && (full[SW-1] != s_a[SW-1]);
                    e.due = cyc + SN;
                    q.push_back(e);
                    sent++;
                end
                @(negedge clk);
                cyc++;
            end
            check($sformatf("w%0d_all_done", SW), 64'(sent == 1000 && q.size() == 0), 64'(1));
            done = 1'b1;
        end
    end

    // ------------------------------------------------------------ main test
    initial begin
        vec_t         vecs[8];
        logic [W-1:0] ra[8];
        logic [W-1:0] rb[8];
        logic         rc[8];
        logic [W-1:0] xa;
        logic [W-1:0] xb;
        logic         xc;
        logic         have;
        logic         acc;
        ent_t         e;
        int           idx;
        int           base;

        vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[2] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[3] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
        vecs[4] = '{16'h0FFF, 16'h0000, 1'b1, 16'h1000, 1'b0, 1'b0};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[6] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};
        vecs[7] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};

        reset     = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        Ci        = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("init_out_valid", 64'(out_valid), 64'(0));
        check("init_sum",       64'(sum),       64'(0));

        // Single op: out_valid must rise exactly NG cycles on, for one cycle.
        for (int i = 0; i < 8; i++) begin
            e     = '{vecs[i].s, vecs[i].co, vecs[i].ovf, 0};
            cycle(1'b1, vecs[i].a, vecs[i].b, vecs[i].ci, 1'b1, e, acc);
            check("vec_accepted", 64'(acc), 64'(1));
            if (i == 0) idle(NG + 1);
        end
        idle(NG + 1);
        check("vec_retired", 64'(n_retired), 64'(8));

        // Eight back-to-back ops with a three-cycle stall once results arrive.
        for (int i = 0; i < 8; i++) begin
            ra[i] = W'($urandom());
            rb[i] = W'($urandom());
            rc[i] = 1'($urandom_range(0, 1));
        end
        base = n_retired;
        idx  = 0;
        for (int cyc = 0; cyc < 40 && n_retired < base + 8; cyc++) begin
            if (idx < 8) begin
                cycle(1'b1, ra[idx], rb[idx], rc[idx], !(cyc >= 4 && cyc <= 6),
                      ref_add(ra[idx], rb[idx], rc[idx]), acc);
                if (acc) idx++;
            end else begin
                e = ref_add('0, '0, 1'b0);
                cycle(1'b0, '0, '0, 1'b0, 1'b1, e, acc);
            end
        end
        check("stream_retired", 64'(n_retired - base), 64'(8));

        // Reset with three operations in flight: none of them may surface.
        for (int i = 0; i < 3; i++) begin
            xa = W'($urandom());
            xb = W'($urandom());
            cycle(1'b1, xa, xb, 1'b0, 1'b1, ref_add(xa, xb, 1'b0), acc);
        end
        base = n_retired;
        pulse_reset();
        idle(NG + 2);
        check("flushed_none_retired", 64'(n_retired - base), 64'(0));
        cycle(1'b1, 16'h00FF, 16'h0101, 1'b1, 1'b1, ref_add(16'h00FF, 16'h0101, 1'b1), acc);
        idle(NG);
        check("post_reset_retired", 64'(n_retired - base), 64'(1));

        // Random traffic with random back-pressure.
        have = 1'b0;
        xa   = '0;
        xb   = '0;
        xc   = 1'b0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (!have) begin
                xa   = W'($urandom());
                xb   = W'($urandom());
                xc   = 1'($urandom_range(0, 1));
                have = ($urandom_range(0, 3) != 0);
            end
            cycle(have, xa, xb, xc, ($urandom_range(0, 3) != 0), ref_add(xa, xb, xc), acc);
            if (acc) have = 1'b0;
        end
        idle(NG + 2);
        check("random_drained", 64'(mq.size()), 64'(0));

        wait (g_sweep[0].done && g_sweep[1].done);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
